// File: rtl/shift_arbiter.sv
// Two-requester shift unit: arbitrates between ports A and B, latches the
// winner's operands, and returns the SLL/SRA/ROR result one cycle later.
module shift_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [1:0]  mode_a,
    input  logic [1:0]  mode_b,
    input  logic [3:0]  val_a,
    input  logic [3:0]  val_b,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic [15:0] result,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit RrEn = (RR_EN != 0);

    state_t      state_q;
    logic        owner_b_q;
    logic        last_b_q;
    logic [1:0]  mode_q;
    logic [3:0]  val_q;
    logic [15:0] data_q;
    logic        gnt_a_q, gnt_b_q, done_a_q, done_b_q, busy_q;
    logic [15:0] result_q;

    logic        pick_b_d;
    logic [15:0] shift_d;

    // B wins only when A is absent, or on a round-robin tie where A went last.
    always_comb begin
        pick_b_d = req_b && (!req_a || (RrEn && !last_b_q));
    end

    always_comb begin
        shift_d = '0;
        case (mode_q)
            2'b00:   shift_d = data_q << val_q;
            2'b01:   shift_d = $signed(data_q) >>> val_q;
            default: shift_d = (data_q >> val_q) | (data_q << (5'd16 - {1'b0, val_q}));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            mode_q    <= '0;
            val_q     <= '0;
            data_q    <= '0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        state_q   <= BUSY;
                        busy_q    <= 1'b1;
                        owner_b_q <= pick_b_d;
                        last_b_q  <= pick_b_d;
                        gnt_a_q   <= !pick_b_d;
                        gnt_b_q   <= pick_b_d;
                        mode_q    <= pick_b_d ? mode_b : mode_a;
                        val_q     <= pick_b_d ? val_b  : val_a;
                        data_q    <= pick_b_d ? data_b : data_a;
                    end
                end
                BUSY: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    result_q <= shift_d;
                    done_a_q <= !owner_b_q;
                    done_b_q <= owner_b_q;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_a  = gnt_a_q;
    assign gnt_b  = gnt_b_q;
    assign done_a = done_a_q;
    assign done_b = done_b_q;
    assign result = result_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a round-robin and a fixed-priority
// instance share all inputs; each task checks one feature inline.
module tb_shift_arbiter;

    logic        clk, rst_n;
    logic        req_a, req_b;
    logic [1:0]  mode_a, mode_b;
    logic [3:0]  val_a, val_b;
    logic [15:0] data_a, data_b;

    logic        r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_busy;
    logic [15:0] r_result;
    logic        f_gnt_a, f_gnt_b, f_done_a, f_done_b, f_busy;
    logic [15:0] f_result;

    int errors = 0;
    int checks = 0;

    shift_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b),
        .mode_a(mode_a), .mode_b(mode_b),
        .val_a(val_a), .val_b(val_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(r_gnt_a), .gnt_b(r_gnt_b),
        .done_a(r_done_a), .done_b(r_done_b),
        .result(r_result), .busy(r_busy)
    );

    shift_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b),
        .mode_a(mode_a), .mode_b(mode_b),
        .val_a(val_a), .val_b(val_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(f_gnt_a), .gnt_b(f_gnt_b),
        .done_a(f_done_a), .done_b(f_done_b),
        .result(f_result), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] r_outs, f_outs;
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        mode_a = '0; mode_b = '0; val_a = '0; val_b = '0;
        data_a = '0; data_b = '0;
        tick();
        r_outs = {r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_busy, |r_result};
        f_outs = {f_gnt_a, f_gnt_b, f_done_a, f_done_b, f_busy, |f_result};
        checks++;
        if (r_outs !== 6'b0) begin
            errors++; $display("FAIL reset_rr: got %b expected 000000", r_outs);
        end
        checks++;
        if (f_outs !== 6'b0) begin
            errors++; $display("FAIL reset_fp: got %b expected 000000", f_outs);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            r_outs = {r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_busy, |r_result};
            checks++;
            if (r_outs !== 6'b0) begin
                errors++; $display("FAIL idle_no_req: cycle %0d got %b expected 000000", i, r_outs);
            end
        end
    endtask

    task automatic test_sll_a();
        req_a = 1'b1; mode_a = 2'b00; val_a = 4'd4; data_a = 16'h00F1;
        tick();
        checks++;
        if ({r_gnt_a, r_gnt_b, r_busy} !== 3'b101) begin
            errors++; $display("FAIL sll_gnt: gnt_a,gnt_b,busy=%b expected 101", {r_gnt_a, r_gnt_b, r_busy});
        end
        req_a = 1'b0;
        tick();
        checks++;
        if ({r_gnt_a, r_done_a, r_done_b} !== 3'b010 || r_result !== 16'h0F10) begin
            errors++; $display("FAIL sll_done: gnt_a,done_a,done_b=%b result=%h expected 010 0f10",
                               {r_gnt_a, r_done_a, r_done_b}, r_result);
        end
        tick();
        checks++;
        if ({r_done_a, r_busy} !== 2'b00 || r_result !== 16'h0F10) begin
            errors++; $display("FAIL sll_hold: done_a,busy=%b result=%h expected 00 0f10",
                               {r_done_a, r_busy}, r_result);
        end
    endtask

    task automatic test_b_ops();
        logic [1:0]  modes [9] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01};
        logic [3:0]  vals  [9] = '{4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd15, 4'd15, 4'd15};
        logic [15:0] datas [9] = '{16'h8000, 16'h0001, 16'h1234, 16'h8765, 16'hA5C3,
                                   16'h1234, 16'h0001, 16'h7FFF, 16'h8000};
        logic [15:0] exps  [9] = '{16'hF000, 16'h8000, 16'h1234, 16'h8765, 16'hA5C3,
                                   16'h4123, 16'h8000, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 9; i++) begin
            req_b = 1'b1; mode_b = modes[i]; val_b = vals[i]; data_b = datas[i];
            tick();
            checks++;
            if ({r_gnt_a, r_gnt_b} !== 2'b01) begin
                errors++; $display("FAIL b_gnt[%0d]: gnt_a,gnt_b=%b expected 01", i, {r_gnt_a, r_gnt_b});
            end
            req_b = 1'b0;
            tick();
            checks++;
            if ({r_done_a, r_done_b} !== 2'b01 || r_result !== exps[i]) begin
                errors++; $display("FAIL b_op[%0d]: done_a,done_b=%b result=%h expected 01 %h",
                                   i, {r_done_a, r_done_b}, r_result, exps[i]);
            end
            tick();
        end
    endtask

    task automatic start_both_held();
        rst_n = 1'b0;
        req_a = 1'b1; mode_a = 2'b00; val_a = 4'd1; data_a = 16'h0001;
        req_b = 1'b1; mode_b = 2'b00; val_b = 4'd2; data_b = 16'h0010;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic        a_turn;
        logic [15:0] exp_res;
        start_both_held();
        for (int i = 0; i < 4; i++) begin
            a_turn  = (i % 2 == 0);
            exp_res = a_turn ? 16'h0002 : 16'h0040;
            tick();
            checks++;
            if ({r_gnt_a, r_gnt_b} !== {a_turn, !a_turn}) begin
                errors++; $display("FAIL rr_gnt[%0d]: gnt_a,gnt_b=%b expected %b",
                                   i, {r_gnt_a, r_gnt_b}, {a_turn, !a_turn});
            end
            tick();
            checks++;
            if ({r_done_a, r_done_b} !== {a_turn, !a_turn} || r_result !== exp_res) begin
                errors++; $display("FAIL rr_done[%0d]: done_a,done_b=%b result=%h expected %b %h",
                                   i, {r_done_a, r_done_b}, r_result, {a_turn, !a_turn}, exp_res);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_fixed_priority();
        start_both_held();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({f_gnt_a, f_gnt_b} !== 2'b10) begin
                errors++; $display("FAIL fp_gnt[%0d]: gnt_a,gnt_b=%b expected 10", i, {f_gnt_a, f_gnt_b});
            end
            tick();
            checks++;
            if ({f_done_a, f_done_b} !== 2'b10 || f_result !== 16'h0002) begin
                errors++; $display("FAIL fp_done[%0d]: done_a,done_b=%b result=%h expected 10 0002",
                                   i, {f_done_a, f_done_b}, f_result);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_op();
        logic [5:0] outs;
        req_a = 1'b1; mode_a = 2'b10; val_a = 4'd4; data_a = 16'hABCD;
        tick();
        checks++;
        if (r_busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: busy=%b expected 1", r_busy);
        end
        rst_n = 1'b0;
        #1;
        outs = {r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_busy, |r_result};
        checks++;
        if (outs !== 6'b0) begin
            errors++; $display("FAIL mid_async: outputs=%b expected 000000", outs);
        end
        tick();
        outs = {r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_busy, |r_result};
        checks++;
        if (outs !== 6'b0) begin
            errors++; $display("FAIL mid_no_done: outputs=%b expected 000000", outs);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({r_gnt_a, r_busy} !== 2'b11) begin
            errors++; $display("FAIL mid_regrant: gnt_a,busy=%b expected 11", {r_gnt_a, r_busy});
        end
        req_a = 1'b0;
        tick();
        checks++;
        if (r_done_a !== 1'b1 || r_result !== 16'hDABC) begin
            errors++; $display("FAIL mid_result: done_a=%b result=%h expected 1 dabc", r_done_a, r_result);
        end
        tick();
    endtask

    task automatic test_isolation();
        req_a = 1'b1; mode_a = 2'b10; val_a = 4'd8; data_a = 16'h1234;
        tick();
        checks++;
        if (r_gnt_a !== 1'b1) begin
            errors++; $display("FAIL iso_gnt: gnt_a=%b expected 1", r_gnt_a);
        end
        req_a = 1'b0; data_a = 16'hFFFF; mode_a = 2'b00; val_a = 4'd1;
        tick();
        checks++;
        if (r_done_a !== 1'b1 || r_result !== 16'h3412) begin
            errors++; $display("FAIL iso_result: done_a=%b result=%h expected 1 3412", r_done_a, r_result);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sll_a();
        test_b_ops();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_op();
        test_isolation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning: 1 = round-robin arbitration, 0 = fixed priority to port A.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_a / req_b, input, 1 bit each: shift request from requester A / B.
REQ-005 The block SHALL have port mode_a / mode_b, input, 2 bits each: operation, 00 = SLL, 01 = SRA, 10 or 11 = ROR.
REQ-006 The block SHALL have port val_a / val_b, input, 4 bits each: shift amount 0-15.
REQ-007 The block SHALL have port data_a / data_b, input, 16 bits each: operand.
REQ-008 The block SHALL have port gnt_a / gnt_b, output, 1 bit each: registered one-cycle grant pulse.
REQ-009 The block SHALL have port done_a / done_b, output, 1 bit each: registered one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 16 bits: shared result bus, valid while done_a or done_b is high.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in flight (state BUSY).

Function
REQ-012 The FSM SHALL have two states, IDLE and BUSY.
REQ-013 In IDLE with req_a or req_b high at a rising edge, the block SHALL go to BUSY, latch the winner's mode, val and data, and record the winner as owner.
REQ-014 In the same edge as REQ-013 the block SHALL assert exactly one of gnt_a/gnt_b; gnt SHALL remain high for exactly the one BUSY cycle.
REQ-015 In IDLE with no request, the block SHALL stay in IDLE with all pulses low.
REQ-016 In BUSY, the next edge SHALL register the shift of the latched operands onto result, pulse done of the owner for one cycle, and return to IDLE.
REQ-017 Latency SHALL be: req sampled at edge k -> gnt high in cycle k..k+1 -> done and result in cycle k+1..k+2; throughput SHALL be one operation per 2 cycles.
REQ-018 SLL SHALL shift left and zero-fill; SRA SHALL shift right and replicate bit 15; ROR SHALL rotate right; all on 16 bits; val = 0 SHALL return data unchanged.
REQ-019 The block SHALL ignore requests sampled while in BUSY; the requester SHALL hold req and operands stable until it sees its gnt.
REQ-020 A req still high in the IDLE cycle following done SHALL be treated as a new request.
REQ-021 With RR_EN = 1 and both req high in IDLE, the block SHALL grant the port not granted most recently; a single requester SHALL always win regardless of history.
REQ-022 With RR_EN = 0 and both req high in IDLE, the block SHALL always grant A.
REQ-023 Operands SHALL be taken only from the latched copy; input changes during BUSY SHALL NOT affect result.
REQ-024 result SHALL hold its last value between done pulses.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, and gnt_a, gnt_b, done_a, done_b, busy = 0, result = 16'h0000, and the last-granted pointer = B, so A wins the first tie.
REQ-026 Reset asserted while in BUSY SHALL abort the operation with no done pulse; operation SHALL resume on the first rising edge after rst_n goes high.

Verification
REQ-027 A-only SLL: req_a = 1, mode 00, val 4, data 16'h00F1 -> gnt_a in the next cycle, then done_a with result = 16'h0F10 and done_b = 0.
REQ-028 B-only SRA and ROR: data 16'h8000, val 3, mode 01 -> result 16'hF000; data 16'h0001, val 1, mode 10 -> 16'h8000; val 0, any mode -> data unchanged.
REQ-029 Round-robin: both req held high from reset release, RR_EN = 1 -> grants A, B, A, B on every other cycle, with done matching the owner each time.
REQ-030 Fixed priority: both req held high, RR_EN = 0 -> every grant goes to A and B never receives gnt.
REQ-031 Reset mid-operation: pull rst_n low during a BUSY cycle -> no done; all outputs 0 while low; after release a held req_a is granted within 1 cycle.
REQ-032 Operand isolation: change data_a to 16'hFFFF during the BUSY cycle -> result reflects the originally latched operand.
